chip_gate_tester: RTL and testbench

Parametrised successor to the single-chip inverter checkers. It exhaustively tests a quad/hex logic-gate DUT of selectable function (NOT, AND, NAND, OR, NOR, XOR) with configurable gate count and fan-in. It drives every input combination to all gates in parallel, waits a programmable settle time, and samples synchronised DUT outputs. It reports pass/fail plus a per-gate failure mask, and sits between the board-level pin mux and the result display logic.

---
 rtl/chip_test_pkg.sv | 34 +++
 rtl/gate_ref_model.sv | 33 +++
 rtl/chip_gate_tester.sv | 156 +++++++++++++++
 tb/tb_chip_gate_tester.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/chip_test_pkg.sv
// -----------------------------------------------------------------------------
// chip_test_pkg
// Shared types and constants for the logic-gate chip tester.
//   mode_t           : 3-bit gate-function code driven on Mode
//   state_t          : tester sequencing states
//   MODE_INVALID_MIN : first Mode code that does not name a gate function
//   mode_is_valid()  : true when a raw Mode code names a gate function
// -----------------------------------------------------------------------------
package chip_test_pkg;

   typedef enum logic [2:0] {
      MODE_NOT  = 3'd0,
      MODE_AND  = 3'd1,
      MODE_NAND = 3'd2,
      MODE_OR   = 3'd3,
      MODE_NOR  = 3'd4,
      MODE_XOR  = 3'd5
   } mode_t;

   typedef enum logic [2:0] {
      HALTED,
      SET,
      DRIVE,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [2:0] MODE_INVALID_MIN = 3'd6;

   function automatic logic mode_is_valid(input logic [2:0] code);
      return (code < MODE_INVALID_MIN);
   endfunction

endpackage

// File: rtl/gate_ref_model.sv
// -----------------------------------------------------------------------------
// gate_ref_model
// Combinational golden output of one gate of the selected function for the
// input vector currently being applied.
//   FANIN    : inputs per gate
//   mode     : in  gate function
//   vector   : in  FANIN-bit input combination
//   expected : out output a good gate must produce
// -----------------------------------------------------------------------------
module gate_ref_model
   import chip_test_pkg::*;
#(
   parameter int FANIN = 2
) (
   input  mode_t            mode,
   input  logic [FANIN-1:0] vector,
   output logic             expected
);

   always_comb begin
      expected = 1'b0;
      case (mode)
         MODE_NOT:  expected = ~vector[0];   // inverter only looks at input 0
         MODE_AND:  expected = &vector;
         MODE_NAND: expected = ~(&vector);
         MODE_OR:   expected = |vector;
         MODE_NOR:  expected = ~(|vector);
         MODE_XOR:  expected = ^vector;
         default:   expected = 1'b0;
      endcase
   end

endmodule

// File: rtl/chip_gate_tester.sv
// -----------------------------------------------------------------------------
// chip_gate_tester
// Exhaustive tester for a multi-gate logic chip. Applies every FANIN-bit input
// combination to all gates at once, waits SETTLE cycles, compares the
// synchronised chip outputs against the golden function and accumulates a
// per-gate failure mask. Result is held until the display acknowledges it.
//
// Ports:
//   Clk        in  system clock
//   Reset_n    in  asynchronous active-low reset
//   Run        in  start request (only honoured in HALTED)
//   Mode       in  3-bit gate function code, latched at start
//   Drive      out gate inputs, gate g input i at bit g*FANIN+i
//   Sense      in  gate outputs, asynchronous to Clk
//   DISP_RSLT  in  display acknowledge, returns tester to HALTED
//   Done       out test complete
//   RSLT       out 1 = every gate passed
//   Fail_mask  out bit g set = gate g mismatched at least once
//
// state  | meaning
// -------+------------------------------------------------------------------
// HALTED | idle, Drive low, result held, waiting for Run
// SET    | latch Mode, clear mask/vector/counter, reject invalid modes
// DRIVE  | current vector applied, settle counter running
// SAMPLE | compare synchronised Sense with golden output, advance vector
// DONE   | Done high, Drive low, waiting for DISP_RSLT
// -----------------------------------------------------------------------------
module chip_gate_tester
   import chip_test_pkg::*;
#(
   parameter int GATES  = 4,
   parameter int FANIN  = 2,
   parameter int SETTLE = 4
) (
   input  logic                   Clk,
   input  logic                   Reset_n,
   input  logic                   Run,
   input  logic [2:0]             Mode,
   output logic [GATES*FANIN-1:0] Drive,
   input  logic [GATES-1:0]       Sense,
   input  logic                   DISP_RSLT,
   output logic                   Done,
   output logic                   RSLT,
   output logic [GATES-1:0]       Fail_mask
);

   localparam int               CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE - 1);
   localparam logic [FANIN-1:0] VEC_LAST = {FANIN{1'b1}};

   state_t                 state_q;
   state_t                 state_d;
   mode_t                  mode_q;
   logic [FANIN-1:0]       vec_q;
   logic [FANIN-1:0]       vec_d;
   logic [CW-1:0]          cnt_q;
   logic [CW-1:0]          cnt_d;
   logic [GATES-1:0]       sense_meta;
   logic [GATES-1:0]       sense_sync;
   logic                   expected;
   logic [GATES-1:0]       mismatch;
   logic [GATES*FANIN-1:0] drive_d;
   logic                   done_d;
   logic                   rslt_d;
   logic [GATES-1:0]       mask_d;

   gate_ref_model #(
      .FANIN    (FANIN)
   ) u_ref (
      .mode     (mode_q),
      .vector   (vec_q),
      .expected (expected)
   );

   assign mismatch = sense_sync ^ {GATES{expected}};

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= HALTED;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         HALTED: if (Run)                  state_d = SET;
         SET:    state_d = mode_is_valid(Mode) ? DRIVE : DONE;
         DRIVE:  if (cnt_q == CNT_LAST)    state_d = SAMPLE;
         SAMPLE: state_d = (vec_q == VEC_LAST) ? DONE : DRIVE;
         DONE:   if (DISP_RSLT)            state_d = HALTED;
         default: state_d = HALTED;
      endcase
   end

   // Next values for every registered output and datapath register. Drive is
   // derived from the next state and next vector so it changes on the very
   // edge that enters DRIVE with a new combination.
   always_comb begin
      vec_d  = vec_q;
      cnt_d  = cnt_q;
      mask_d = Fail_mask;
      rslt_d = RSLT;
      case (state_q)
         SET: begin
            vec_d  = '0;
            cnt_d  = '0;
            rslt_d = 1'b0;
            mask_d = mode_is_valid(Mode) ? '0 : '1;
         end
         DRIVE: begin
            cnt_d = (state_d == SAMPLE) ? '0 : cnt_q + 1'b1;
         end
         SAMPLE: begin
            mask_d = Fail_mask | mismatch;
            cnt_d  = '0;
            if (state_d == DONE) begin
               rslt_d = ~(|mask_d);
            end else begin
               vec_d = vec_q + 1'b1;
            end
         end
         default: ;
      endcase
      done_d  = (state_d == DONE);
      drive_d = ((state_d == DRIVE) || (state_d == SAMPLE)) ? {GATES{vec_d}} : '0;
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         mode_q     <= MODE_NOT;
         vec_q      <= '0;
         cnt_q      <= '0;
         sense_meta <= '0;
         sense_sync <= '0;
         Drive      <= '0;
         Done       <= 1'b0;
         RSLT       <= 1'b0;
         Fail_mask  <= '0;
      end else begin
         if ((state_q == SET) && mode_is_valid(Mode)) begin
            mode_q <= mode_t'(Mode);
         end
         vec_q      <= vec_d;
         cnt_q      <= cnt_d;
         sense_meta <= Sense;
         sense_sync <= sense_meta;
         Drive      <= drive_d;
         Done       <= done_d;
         RSLT       <= rslt_d;
         Fail_mask  <= mask_d;
      end
   end

endmodule

// File: tb/tb_chip_gate_tester.sv
// -----------------------------------------------------------------------------
// tb_chip_gate_tester
// Two tester instances: A (GATES=4, FANIN=2, SETTLE=4) against a behavioural
// chip with injectable stuck-at faults, and B (GATES=6, FANIN=1, SETTLE=3)
// against an ideal hex inverter.
// -----------------------------------------------------------------------------
module tb_chip_gate_tester;

   localparam int GA = 4;
   localparam int FA = 2;
   localparam int SA = 4;

   logic Clk = 1'b0;
   always #5 Clk = ~Clk;

   logic reset_n;

   logic         run_a, disp_a;
   logic [2:0]   mode_a;
   logic [7:0]   drive_a;
   logic [3:0]   sense_a;
   logic         done_a, rslt_a;
   logic [3:0]   mask_a;

   logic         run_b, disp_b;
   logic [2:0]   mode_b;
   logic [5:0]   drive_b;
   logic [5:0]   sense_b;
   logic         done_b, rslt_b;
   logic [5:0]   mask_b;

   int           chip_mode;
   logic [3:0]   stuck_en;
   logic [3:0]   stuck_val;

   int n_checks = 0;
   int n_fail   = 0;

   chip_gate_tester #(.GATES(GA), .FANIN(FA), .SETTLE(SA)) u_dut_a (
      .Clk       (Clk),
      .Reset_n   (reset_n),
      .Run       (run_a),
      .Mode      (mode_a),
      .Drive     (drive_a),
      .Sense     (sense_a),
      .DISP_RSLT (disp_a),
      .Done      (done_a),
      .RSLT      (rslt_a),
      .Fail_mask (mask_a)
   );

   chip_gate_tester #(.GATES(6), .FANIN(1), .SETTLE(3)) u_dut_b (
      .Clk       (Clk),
      .Reset_n   (reset_n),
      .Run       (run_b),
      .Mode      (mode_b),
      .Drive     (drive_b),
      .Sense     (sense_b),
      .DISP_RSLT (disp_b),
      .Done      (done_b),
      .RSLT      (rslt_b),
      .Fail_mask (mask_b)
   );

   // Gate behaviour from the count of ones among the used inputs.
   function automatic logic gate_fn(input int m, input logic [2:0] bits, input int fanin);
      int ones = 0;
      for (int i = 0; i < fanin; i++) ones += int'(bits[i]);
      case (m)
         0:       return !bits[0];
         1:       return ones == fanin;
         2:       return ones != fanin;
         3:       return ones > 0;
         4:       return ones == 0;
         5:       return (ones % 2) == 1;
         default: return 1'b0;
      endcase
   endfunction

   always_comb begin
      sense_a = '0;
      for (int g = 0; g < GA; g++) begin
         sense_a[g] = stuck_en[g] ? stuck_val[g]
                                  : gate_fn(chip_mode, {1'b0, drive_a[g*FA +: FA]}, FA);
      end
   end

   assign sense_b = ~drive_b;

   function automatic logic [3:0] predict_mask(input int m, input int cm,
                                               input logic [3:0] en, input logic [3:0] val);
      logic [3:0] mask;
      logic       act;
      logic       exp;
      mask = 4'h0;
      if (m >= 6) return 4'hF;
      for (int v = 0; v < (1 << FA); v++) begin
         exp = gate_fn(m, 3'(v), FA);
         for (int g = 0; g < GA; g++) begin
            act = en[g] ? val[g] : gate_fn(cm, 3'(v), FA);
            if (act != exp) mask[g] = 1'b1;
         end
      end
      return mask;
   endfunction

   function automatic int predict_lat(input int m);
      return (m >= 6) ? 2 : 2 + (1 << FA) * (SA + 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // lat counts clock edges, the edge that samples Run being edge 1.
   task automatic start_and_wait(input logic [2:0] m, output int lat);
      @(negedge Clk);
      mode_a = m;
      run_a  = 1'b1;
      @(posedge Clk);
      #1;
      run_a = 1'b0;
      lat   = 1;
      while (!done_a && lat < 200) begin
         @(posedge Clk);
         #1;
         lat++;
         if (lat == 2) mode_a = 3'($urandom);
      end
   endtask

   task automatic release_a(input string name);
      @(negedge Clk);
      disp_a = 1'b1;
      @(posedge Clk);
      #1;
      check({name, "_done_low_after_ack"}, 32'(done_a), 32'd0);
      @(negedge Clk);
      disp_a = 1'b0;
   endtask

   task automatic run_case(input string name, input logic [2:0] m, input int cm,
                           input logic [3:0] en, input logic [3:0] val,
                           input logic exp_rslt, input logic [3:0] exp_mask, input int exp_lat);
      int lat;
      chip_mode = cm;
      stuck_en  = en;
      stuck_val = val;
      start_and_wait(m, lat);
      check({name, "_done"},  32'(done_a),  32'd1);
      check({name, "_lat"},   32'(lat),     32'(exp_lat));
      check({name, "_rslt"},  32'(rslt_a),  32'(exp_rslt));
      check({name, "_mask"},  32'(mask_a),  32'(exp_mask));
      check({name, "_drive"}, 32'(drive_a), 32'd0);
      release_a(name);
   endtask

   typedef struct {
      logic [2:0] mode;
      int         chip;
      logic [3:0] en;
      logic [3:0] val;
      logic       rslt;
      logic [3:0] mask;
      int         lat;
   } vec_t;

   vec_t tbl[12];

   initial begin
      int         lat;
      int         m, cm;
      logic [3:0] en, val;
      logic [5:0] drv[64];

      tbl[0]  = '{3'd2, 2, 4'h0, 4'h0, 1'b1, 4'h0, 22};  // NAND ideal
      tbl[1]  = '{3'd1, 1, 4'h4, 4'h4, 1'b0, 4'h4, 22};  // AND, gate 2 stuck-at-1
      tbl[2]  = '{3'd7, 1, 4'h0, 4'h0, 1'b0, 4'hF,  2};  // invalid mode 7
      tbl[3]  = '{3'd6, 0, 4'h0, 4'h0, 1'b0, 4'hF,  2};  // invalid mode 6
      tbl[4]  = '{3'd5, 5, 4'h1, 4'h0, 1'b0, 4'h1, 22};  // XOR, gate 0 stuck-at-0
      tbl[5]  = '{3'd3, 4, 4'h0, 4'h0, 1'b0, 4'hF, 22};  // OR tester on NOR chip
      tbl[6]  = '{3'd0, 0, 4'h8, 4'h8, 1'b0, 4'h8, 22};  // NOT, gate 3 stuck-at-1
      tbl[7]  = '{3'd4, 4, 4'h2, 4'h0, 1'b0, 4'h2, 22};  // NOR, gate 1 stuck-at-0
      tbl[8]  = '{3'd3, 3, 4'h8, 4'h0, 1'b0, 4'h8, 22};  // OR, gate 3 stuck-at-0
      tbl[9]  = '{3'd0, 5, 4'h0, 4'h0, 1'b0, 4'hF, 22};  // NOT tester on XOR chip
      tbl[10] = '{3'd5, 5, 4'h0, 4'h0, 1'b1, 4'h0, 22};  // XOR ideal
      tbl[11] = '{3'd1, 1, 4'hF, 4'h0, 1'b0, 4'hF, 22};  // AND, all stuck-at-0

      reset_n   = 1'b0;
      run_a     = 1'b0;
      disp_a    = 1'b0;
      mode_a    = 3'd0;
      run_b     = 1'b0;
      disp_b    = 1'b0;
      mode_b    = 3'd0;
      chip_mode = 2;
      stuck_en  = 4'h0;
      stuck_val = 4'h0;

      repeat (3) @(posedge Clk);
      #1;
      check("reset_drive", 32'(drive_a), 32'd0);
      check("reset_done",  32'(done_a),  32'd0);
      check("reset_rslt",  32'(rslt_a),  32'd0);
      check("reset_mask",  32'(mask_a),  32'd0);
      @(negedge Clk);
      reset_n = 1'b1;
      repeat (3) begin
         @(posedge Clk);
         #1;
         check("idle_done",  32'(done_a),  32'd0);
         check("idle_drive", 32'(drive_a), 32'd0);
      end

      foreach (tbl[i])
         run_case($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].chip, tbl[i].en,
                  tbl[i].val, tbl[i].rslt, tbl[i].mask, tbl[i].lat);

      // DONE held without acknowledge; Run there is ignored.
      chip_mode = 1; stuck_en = 4'h4; stuck_val = 4'h4;
      start_and_wait(3'd1, lat);
      check("hold_entry_mask", 32'(mask_a), 32'h4);
      for (int c = 0; c < 10; c++) begin
         @(negedge Clk);
         run_a = 1'b1;
         @(posedge Clk);
         #1;
         check("hold_done", 32'(done_a), 32'd1);
         check("hold_mask", 32'(mask_a), 32'h4);
         check("hold_rslt", 32'(rslt_a), 32'd0);
      end
      @(negedge Clk);
      disp_a = 1'b1;
      @(posedge Clk);
      #1;
      check("ack_with_run_done", 32'(done_a), 32'd0);
      @(negedge Clk);
      disp_a = 1'b0;
      run_a  = 1'b0;
      repeat (3) begin
         @(posedge Clk);
         #1;
         check("halted_done",       32'(done_a),  32'd0);
         check("halted_drive",      32'(drive_a), 32'd0);
         check("halted_mask_holds", 32'(mask_a),  32'h4);
      end
      stuck_en = 4'h0;
      @(negedge Clk);
      mode_a = 3'd1;
      run_a  = 1'b1;
      @(posedge Clk);
      #1;
      run_a = 1'b0;
      check("set_mask_not_yet_cleared", 32'(mask_a), 32'h4);
      @(posedge Clk);
      #1;
      check("set_mask_cleared", 32'(mask_a), 32'h0);
      lat = 2;
      while (!done_a && lat < 200) begin
         @(posedge Clk);
         #1;
         lat++;
      end
      check("restart_lat",  32'(lat),    32'd22);
      check("restart_rslt", 32'(rslt_a), 32'd1);
      check("restart_mask", 32'(mask_a), 32'h0);
      release_a("restart");

      // Reset in the middle of DRIVE.
      chip_mode = 1; stuck_en = 4'h4; stuck_val = 4'h4;
      @(negedge Clk);
      mode_a = 3'd1;
      run_a  = 1'b1;
      @(posedge Clk);
      #1;
      run_a = 1'b0;
      repeat (7) @(posedge Clk);
      #1;
      check("mid_drive_vector1", 32'(drive_a), 32'h55);
      check("mid_drive_mask",    32'(mask_a),  32'h4);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_drive", 32'(drive_a), 32'd0);
      check("async_rst_mask",  32'(mask_a),  32'd0);
      check("async_rst_done",  32'(done_a),  32'd0);
      @(negedge Clk);
      reset_n = 1'b1;
      repeat (3) begin
         @(posedge Clk);
         #1;
         check("post_rst_done",  32'(done_a),  32'd0);
         check("post_rst_drive", 32'(drive_a), 32'd0);
      end

      // Reset while showing a passing result.
      chip_mode = 2; stuck_en = 4'h0;
      start_and_wait(3'd2, lat);
      check("pre_rst_rslt", 32'(rslt_a), 32'd1);
      check("pre_rst_done", 32'(done_a), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("async_rst_rslt2", 32'(rslt_a), 32'd0);
      check("async_rst_done2", 32'(done_a), 32'd0);
      @(negedge Clk);
      reset_n = 1'b1;
      run_case("after_reset", 3'd2, 2, 4'h0, 4'h0, 1'b1, 4'h0, 22);

      // Randomised runs against the reference model.
      for (int r = 0; r < 24; r++) begin
         m   = int'($urandom_range(0, 7));
         cm  = ($urandom_range(0, 1) == 0 && m < 6) ? m : int'($urandom_range(0, 5));
         en  = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
         val = 4'($urandom);
         run_case($sformatf("rnd%0d_m%0d_c%0d_e%0h_v%0h", r, m, cm, en, val),
                  3'(m), cm, en, val, (predict_mask(m, cm, en, val) == 4'h0),
                  predict_mask(m, cm, en, val), predict_lat(m));
      end

      // Hex inverter on the single-input instance.
      foreach (drv[i]) drv[i] = 6'h00;
      @(negedge Clk);
      mode_b = 3'd0;
      run_b  = 1'b1;
      @(posedge Clk);
      #1;
      run_b  = 1'b0;
      lat    = 1;
      drv[1] = drive_b;
      while (!done_b && lat < 63) begin
         @(posedge Clk);
         #1;
         lat++;
         drv[lat] = drive_b;
      end
      check("b_lat",        32'(lat),     32'd10);
      check("b_rslt",       32'(rslt_b),  32'd1);
      check("b_mask",       32'(mask_b),  32'h0);
      check("b_drive_v0",   32'(drv[2]),  32'h00);
      check("b_drive_smp0", 32'(drv[5]),  32'h00);
      check("b_drive_v1",   32'(drv[6]),  32'h3F);
      check("b_drive_smp1", 32'(drv[9]),  32'h3F);
      check("b_drive_done", 32'(drive_b), 32'h00);
      @(negedge Clk);
      disp_b = 1'b1;
      @(posedge Clk);
      #1;
      check("b_done_low_after_ack", 32'(done_b), 32'd0);
      disp_b = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
